// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall/flush sequencer.
// The master side drives hazard and memory status; the slave side is the controller.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             load_use;
    logic             br_mispred;
    logic             imem_ready;
    logic             dmem_req;
    logic             dmem_ready;
    logic             halt_req;
    logic             resume;
    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_we;
    logic             ex_mem_we;
    logic             mem_wb_we;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output load_use, br_mispred, imem_ready, dmem_req, dmem_ready, halt_req, resume,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        input  if_id_flush, id_ex_flush, halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use, br_mispred, imem_ready, dmem_req, dmem_ready, halt_req, resume,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
        output if_id_flush, id_ex_flush, halted, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Five-stage pipeline sequencer: per-stage enables/flushes from hazards and memory
// readiness, halt drain/resume, and saturating stall/flush performance counters.
module hazard_stall_ctrl #(
    parameter int CNT_W     = 32,
    parameter int DRAIN_CYC = 4
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYC);

    state_t           state;
    logic [3:0]       drain_cnt;
    logic             halt_pend;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic dstall;
    logic frozen;
    logic br_act;
    logic lu_act;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush;

    assign dstall = bus.dmem_req & ~bus.dmem_ready;
    // MEM_WAIT keeps everything frozen until the data access completes, even if dmem_req drops
    assign frozen = dstall | ((state == MEM_WAIT) & ~bus.dmem_ready);

    always_comb begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        br_act      = 1'b0;
        lu_act      = 1'b0;
        if (!rst && state != HALTED && !frozen) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            if (state == DRAIN) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
            if (bus.br_mispred) begin
                // the redirect target is captured even while draining
                pc_we       = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                br_act      = 1'b1;
            end else if (bus.load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
                lu_act      = 1'b1;
            end else if (!bus.imem_ready && state != DRAIN) begin
                pc_we       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
            halt_pend <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state != HALTED && !pc_we && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_act && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (bus.halt_req && state != HALTED)
                halt_pend <= 1'b1;

            case (state)
                RUN: begin
                    if (dstall) begin
                        state <= MEM_WAIT;
                    end else if (halt_pend || bus.halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        if (halt_pend || bus.halt_req) begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_INIT;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (!dstall) begin
                        if (br_act || lu_act) begin
                            drain_cnt <= DRAIN_INIT;
                        end else if (drain_cnt <= 4'd1) begin
                            drain_cnt <= 4'd0;
                            state     <= HALTED;
                            halt_pend <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - 4'd1;
                        end
                    end
                end
                HALTED: begin
                    if (bus.resume)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.pc_we       = pc_we;
    assign bus.if_id_we    = if_id_we;
    assign bus.id_ex_we    = id_ex_we;
    assign bus.ex_mem_we   = ex_mem_we;
    assign bus.mem_wb_we   = mem_wb_we;
    assign bus.if_id_flush = if_id_flush;
    assign bus.id_ex_flush = id_ex_flush;
    assign bus.halted      = (state == HALTED);
    assign bus.state       = state;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a 32-bit-counter instance and a 4-bit-counter
// instance share stimulus; expectations are queued per step and checked mid-cycle.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use, br_mispred, imem_ready, dmem_req, dmem_ready, halt_req, resume;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(32)) ifa ();
    hazard_stall_ctrl_if #(.CNT_W(4))  ifs ();

    assign ifa.load_use   = load_use;    assign ifs.load_use   = load_use;
    assign ifa.br_mispred = br_mispred;  assign ifs.br_mispred = br_mispred;
    assign ifa.imem_ready = imem_ready;  assign ifs.imem_ready = imem_ready;
    assign ifa.dmem_req   = dmem_req;    assign ifs.dmem_req   = dmem_req;
    assign ifa.dmem_ready = dmem_ready;  assign ifs.dmem_ready = dmem_ready;
    assign ifa.halt_req   = halt_req;    assign ifs.halt_req   = halt_req;
    assign ifa.resume     = resume;      assign ifs.resume     = resume;

    hazard_stall_ctrl #(.CNT_W(32), .DRAIN_CYC(4)) dut   (.clk(clk), .rst(rst), .bus(ifa));
    hazard_stall_ctrl #(.CNT_W(4),  .DRAIN_CYC(4)) dut_s (.clk(clk), .rst(rst), .bus(ifs));

    wire [4:0] we_a = {ifa.pc_we, ifa.if_id_we, ifa.id_ex_we, ifa.ex_mem_we, ifa.mem_wb_we};
    wire [4:0] we_s = {ifs.pc_we, ifs.if_id_we, ifs.id_ex_we, ifs.ex_mem_we, ifs.mem_wb_we};
    wire [1:0] fl_a = {ifa.if_id_flush, ifa.id_ex_flush};

    // input vector: {load_use, br_mispred, imem_ready, dmem_req, dmem_ready, halt_req, resume}
    localparam logic [6:0] IDLE = 7'b0010000, LU   = 7'b1010000, BMLU = 7'b1110000;
    localparam logic [6:0] NOIM = 7'b0000000, DSBM = 7'b0111000, DRBM = 7'b0111100;
    localparam logic [6:0] HALT = 7'b0010010, HRRS = 7'b0010011, RS   = 7'b0010001;
    localparam logic [6:0] DS   = 7'b0011000, DR   = 7'b0011100, BM   = 7'b0110000;
    localparam logic [6:0] DSHR = 7'b0011010;
    localparam logic [4:0] ALL = 5'b11111, NONE = 5'b00000, LUWE = 5'b00111, PCOFF = 5'b01111;
    localparam logic [1:0] F0 = 2'b00, FLU = 2'b01, FIM = 2'b10, FBM = 2'b11;
    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_DR = 2'd2, S_HT = 2'd3;

    typedef struct {
        string       tag;
        logic [4:0]  we;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic        hl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_stall = 0;
    logic [31:0] m_flush = 0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [3:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 4'hF : v[3:0];
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        total++; assert (we_a === e.we) else begin bad++; $error("FAIL %s enables got=%b exp=%b", e.tag, we_a, e.we); end
        total++; assert (we_s === e.we) else begin bad++; $error("FAIL %s enables_small got=%b exp=%b", e.tag, we_s, e.we); end
        total++; assert (fl_a === e.fl) else begin bad++; $error("FAIL %s flushes got=%b exp=%b", e.tag, fl_a, e.fl); end
        total++; assert (ifa.state === e.st) else begin bad++; $error("FAIL %s state got=%0d exp=%0d", e.tag, ifa.state, e.st); end
        total++; assert (ifa.halted === e.hl) else begin bad++; $error("FAIL %s halted got=%b exp=%b", e.tag, ifa.halted, e.hl); end
        total++; assert (ifa.stall_cnt === e.sc) else begin bad++; $error("FAIL %s stall_cnt got=%0d exp=%0d", e.tag, ifa.stall_cnt, e.sc); end
        total++; assert (ifa.flush_cnt === e.fc) else begin bad++; $error("FAIL %s flush_cnt got=%0d exp=%0d", e.tag, ifa.flush_cnt, e.fc); end
        total++; assert (ifs.stall_cnt === sat4(e.sc)) else begin bad++; $error("FAIL %s stall_cnt_small got=%0d exp=%0d", e.tag, ifs.stall_cnt, sat4(e.sc)); end
        total++; assert (ifs.flush_cnt === sat4(e.fc)) else begin bad++; $error("FAIL %s flush_cnt_small got=%0d exp=%0d", e.tag, ifs.flush_cnt, sat4(e.fc)); end
    endtask

    task automatic drive(input logic [6:0] in);
        {load_use, br_mispred, imem_ready, dmem_req, dmem_ready, halt_req, resume} = in;
    endtask

    task automatic queue_exp(input string tag, input logic [4:0] ew, input logic [1:0] ef, input logic [1:0] es);
        exp_t e;
        e.tag = tag; e.we = ew; e.fl = ef; e.st = es; e.hl = (es == S_HT);
        e.sc = m_stall; e.fc = m_flush;
        sb.push_back(e);
    endtask

    // one clock cycle: drive just after the edge, check at the falling edge
    task automatic step(input string tag, input logic [6:0] in, input logic [4:0] ew,
                        input logic [1:0] ef, input logic [1:0] es);
        drive(in);
        queue_exp(tag, ew, ef, es);
        #4;
        check_out();
        if (es != S_HT && !ew[4]) m_stall = m_stall + 1;
        if (ew[4] && ef == FBM)   m_flush = m_flush + 1;
        @(posedge clk); #1;
    endtask

    task automatic reset_chk(input string tag);
        rst = 1'b1;
        m_stall = 0;
        m_flush = 0;
        #1;
        queue_exp(tag, NONE, F0, S_RUN);
        check_out();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(IDLE);
        @(posedge clk); #1;
        reset_chk("reset");

        step("run_idle",   IDLE, ALL,  F0,  S_RUN);
        step("load_use",   LU,   LUWE, FLU, S_RUN);
        step("after_lu",   IDLE, ALL,  F0,  S_RUN);
        step("bm_and_lu",  BMLU, ALL,  FBM, S_RUN);
        step("after_bm",   IDLE, ALL,  F0,  S_RUN);
        step("imem_wait",  NOIM, PCOFF, FIM, S_RUN);

        step("dstall_1",   DSBM, NONE, F0,  S_RUN);
        step("dstall_2",   DSBM, NONE, F0,  S_MW);
        step("dstall_3",   DSBM, NONE, F0,  S_MW);
        step("dready_bm",  DRBM, ALL,  FBM, S_MW);
        step("post_mw",    IDLE, ALL,  F0,  S_RUN);

        step("halt_pulse", HALT, ALL,  F0,  S_RUN);
        for (int i = 0; i < 4; i++) step("drain", IDLE, PCOFF, FIM, S_DR);
        step("halted",     IDLE, NONE, F0,  S_HT);
        step("halt_ign",   HALT, NONE, F0,  S_HT);
        step("resume_win", HRRS, NONE, F0,  S_HT);
        step("resumed",    IDLE, ALL,  F0,  S_RUN);
        step("no_pend",    IDLE, ALL,  F0,  S_RUN);

        step("halt2",      HALT, ALL,  F0,  S_RUN);
        step("drain2_c1",  IDLE, PCOFF, FIM, S_DR);
        step("drain2_ds1", DS,   NONE, F0,  S_DR);
        step("drain2_ds2", DS,   NONE, F0,  S_DR);
        for (int i = 0; i < 3; i++) step("drain2", IDLE, PCOFF, FIM, S_DR);
        step("halted2",    IDLE, NONE, F0,  S_HT);
        step("resume2",    RS,   NONE, F0,  S_HT);
        step("run2",       IDLE, ALL,  F0,  S_RUN);

        step("halt3",      HALT, ALL,  F0,  S_RUN);
        step("drain3_c1",  IDLE, PCOFF, FIM, S_DR);
        step("drain3_bm",  BM,   ALL,  FBM, S_DR);
        step("drain3_c2",  IDLE, PCOFF, FIM, S_DR);
        step("drain3_lu",  LU,   LUWE, FBM, S_DR);
        for (int i = 0; i < 4; i++) step("drain3", IDLE, PCOFF, FIM, S_DR);
        step("halted3",    IDLE, NONE, F0,  S_HT);
        step("resume3",    RS,   NONE, F0,  S_HT);

        step("mw_halt",    DSHR, NONE, F0,  S_RUN);
        step("mw_to_drain", DR,  ALL,  F0,  S_MW);
        step("drain4",     IDLE, PCOFF, FIM, S_DR);
        reset_chk("rst_drain");
        step("rst_run1",   IDLE, ALL,  F0,  S_RUN);
        step("rst_run2",   IDLE, ALL,  F0,  S_RUN);

        step("mw_enter",   DS,   NONE, F0,  S_RUN);
        step("mw_hold",    DS,   NONE, F0,  S_MW);
        reset_chk("rst_mw");
        step("post_rst",   IDLE, ALL,  F0,  S_RUN);

        for (int i = 0; i < 20; i++) step("sat_stall", NOIM, PCOFF, FIM, S_RUN);
        step("sat_final",  IDLE, ALL,  F0,  S_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage core (IF/ID/EX/MEM/WB) with a two-bit branch predictor. It combines the ID-stage load-use hazard flag, EX-stage branch mispredict, and instruction/data memory readiness into per-stage register write-enables and flushes. It also drains the pipeline on a halt request and resumes it on command. Stall and flush events are counted for performance monitoring.

## Interface
- CNT_W, 32, width of each performance counter
- DRAIN_CYC, 4, bubble cycles needed to empty ID..WB after fetch stops (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- load_use  in  1  ID instruction sources rd of a load now in EX
- br_mispred  in  1  EX branch outcome/target disagrees with prediction
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage holds a load/store
- dmem_ready  in  1  data memory completes the MEM access this cycle
- halt_req  in  1  request to drain and stop (pulse or level)
- resume  in  1  leave HALTED
- pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  stage register enables
- if_id_flush, id_ex_flush  out  1 each  load bubble (NOP) into IF/ID, ID/EX (takes effect when the matching _we is 1)
- halted  out  1  pipeline empty and stopped
- state  out  2  RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- Enables and flushes are combinational from state and inputs; state, drain counter, halt_pend and counters are registered.
- dstall = dmem_req & ~dmem_ready.
- Default (no event): every _we=1, flushes=0.
- Priority in RUN and DRAIN: dstall > br_mispred > load_use > ~imem_ready.
  - dstall: all _we=0, no flush; RUN -> MEM_WAIT; DRAIN stays, drain counter holds.
  - br_mispred: all _we=1, if_id_flush=1, id_ex_flush=1; flush_cnt++. In DRAIN the PC still captures the redirect target, so resume fetches correctly.
  - load_use: pc_we=0, if_id_we=0, id_ex_flush=1.
  - ~imem_ready (RUN only): pc_we=0, if_id_flush=1.
- While dstall, br_mispred and load_use are ignored; they are held by the frozen pipeline and acted on after release.
- MEM_WAIT: all _we=0 while dmem_ready=0.
  - On dmem_ready=1, outputs evaluate as RUN with dstall=0.
  - Next state is DRAIN if halt_pend, else RUN.
- halt_req sets halt_pend in any state except HALTED.
- RUN with halt_pend (or halt_req) and no dstall: this cycle evaluates normally; next state DRAIN with drain counter = DRAIN_CYC.
- DRAIN:
  - pc_we=0, if_id_flush=1 every cycle; mispredict overrides pc_we=1.
  - Drain counter decrements on each cycle with mem_wb_we=1.
  - On reaching 0: HALTED, halt_pend cleared.
  - A mispredict or load_use in DRAIN reloads the counter to DRAIN_CYC.
- HALTED: all _we=0, flushes=0, halted=1. resume=1 -> RUN next cycle. halt_req is ignored.
- stall_cnt increments on each cycle with pc_we=0 and state!=HALTED.
- Both counters saturate at all-ones and never wrap.

## Timing
- While rst=1: state=RUN, all _we=0, flushes=0, halted=0, counters=0, halt_pend=0, drain counter=0.
- After rst falls, first clk edge behaves as RUN.
- Zero-cycle latency from inputs to enables; the stage registers sample them on the same edge.
- Load-use costs exactly 1 bubble when load_use drops the next cycle.
- A mispredict costs 2 squashed instructions.
- Halt latency from halt_req to halted=1 is DRAIN_CYC+1 cycles, plus stall and reload cycles.
- resume and halt_req in the same cycle while HALTED: resume wins.
- Reset mid-DRAIN or mid-MEM_WAIT returns straight to RUN; halt_pend is lost.

## Test plan
- RUN, load_use=1 for 1 cycle -> that cycle pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt 0->1; next cycle all _we=1.
- br_mispred=1 together with load_use=1 -> pc_we=1, both flushes=1; flush_cnt=1; stall_cnt unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles with br_mispred=1 -> all _we=0 for 3 cycles, state=1; on dmem_ready mispredict flush applied, state=0, stall_cnt=3.
- halt_req pulse in RUN, DRAIN_CYC=4, no stalls -> state 2 for 4 cycles with pc_we=0 and if_id_flush=1; halted=1 on cycle 6; resume -> state=0, pc_we=1.
- Dstall on drain cycle 2 for 2 cycles -> drain counter holds; halted is delayed by 2 cycles.
- CNT_W=4: hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15. Assert rst mid-MEM_WAIT -> all outputs at reset values immediately.
